// File: rtl/fp_align_stage.sv
// ----------------------------------------------------------------------------
// fp_align_stage
//
// Front end of the pipelined floating-point add/sub unit. Two IEEE-754 single
// operands are unpacked, the operation sign is folded into B, and the operands
// are ordered by magnitude (stage S1). The smaller mantissa is then
// right-aligned to the larger exponent with guard/round/sticky bits (stage S2).
// NaN/Inf inputs are decoded here and bypass the datapath as a packed result.
//
// Optional feature macro: SUBNORMAL_EN
//   defined   : exponent 0 with nonzero fraction is treated as a subnormal
//               (hidden bit 0, effective exponent 1)
//   undefined : subnormal inputs are flushed to signed zero
//
// Ports
//   Clk           rising-edge clock
//   Rst_n         asynchronous active-low reset
//   InValid       operand pair valid
//   InReady       stage accepts operands this cycle
//   OperandA      first operand (IEEE single)
//   OperandB      second operand (IEEE single)
//   Operation     0 = A+B, 1 = A-B
//   OutValid      output bundle valid
//   OutReady      downstream accepts bundle
//   ExponentBase  exponent of the larger-magnitude operand
//   MantissaLarge {hidden, fraction, 3'b000} of the larger operand
//   MantissaSmall aligned smaller mantissa, bit 0 is sticky
//   EffSub        effective subtraction
//   ResultSign    sign of the result
//   SpecialCase   NaN/Inf result, datapath outputs are zero
//   SpecialResult packed special result, valid when SpecialCase is set
// ----------------------------------------------------------------------------
module fp_align_stage #(
    parameter int DataSize     = 32,
    parameter int FractionSize = 23,
    parameter int ExponentSize = 8,
    parameter int MantissaSize = FractionSize + 1,
    parameter int RoundingSize = MantissaSize + 3
) (
    input  logic                    Clk,
    input  logic                    Rst_n,
    input  logic                    InValid,
    output logic                    InReady,
    input  logic [DataSize-1:0]     OperandA,
    input  logic [DataSize-1:0]     OperandB,
    input  logic                    Operation,
    output logic                    OutValid,
    input  logic                    OutReady,
    output logic [ExponentSize-1:0] ExponentBase,
    output logic [RoundingSize-1:0] MantissaLarge,
    output logic [RoundingSize-1:0] MantissaSmall,
    output logic                    EffSub,
    output logic                    ResultSign,
    output logic                    SpecialCase,
    output logic [DataSize-1:0]     SpecialResult
);

    localparam logic [ExponentSize-1:0] ExpOnes    = {ExponentSize{1'b1}};
    localparam logic [ExponentSize-1:0] ExpOne     = {{(ExponentSize-1){1'b0}}, 1'b1};
    localparam logic [ExponentSize-1:0] RoundLimit = ExponentSize'(RoundingSize);
    localparam logic [DataSize-1:0]     QuietNaN   =
        {1'b0, {ExponentSize{1'b1}}, 1'b1, {(FractionSize-1){1'b0}}};

    // ------------------------------------------------------------------
    // Handshake: each stage advances when it is empty or the stage after
    // it advances, so a full pipe still moves one pair per cycle.
    // ------------------------------------------------------------------
    logic s1Valid_q, s1Valid_d;
    logic outValid_q, outValid_d;
    logic s1Advance, s2Advance;

    assign s2Advance = ~outValid_q | OutReady;
    assign s1Advance = ~s1Valid_q | s2Advance;
    assign InReady   = s1Advance;

    // ------------------------------------------------------------------
    // Unpack and compare (combinational, feeds the S1 registers)
    // ------------------------------------------------------------------
    logic                    signA, signB;
    logic [ExponentSize-1:0] expRawA, expRawB, expA, expB, expEffA, expEffB;
    logic [FractionSize-1:0] fracRawA, fracRawB, fracA, fracB;
    logic                    hiddenA, hiddenB;
    logic                    aIsLarge, equalMag, effSubIn;
    logic                    nanA, nanB, infA, infB, specialIn;
    logic [DataSize-1:0]     specialResIn;

    always_comb begin
        signA    = OperandA[DataSize-1];
        signB    = OperandB[DataSize-1] ^ Operation;
        expRawA  = OperandA[DataSize-2 -: ExponentSize];
        expRawB  = OperandB[DataSize-2 -: ExponentSize];
        fracRawA = OperandA[FractionSize-1:0];
        fracRawB = OperandB[FractionSize-1:0];
        expA     = expRawA;
        expB     = expRawB;
`ifdef SUBNORMAL_EN
        fracA    = fracRawA;
        fracB    = fracRawB;
        expEffA  = (expRawA == '0 && fracRawA != '0) ? ExpOne : expRawA;
        expEffB  = (expRawB == '0 && fracRawB != '0) ? ExpOne : expRawB;
`else
        fracA    = (expRawA == '0) ? '0 : fracRawA;
        fracB    = (expRawB == '0) ? '0 : fracRawB;
        expEffA  = expRawA;
        expEffB  = expRawB;
`endif
        hiddenA  = (expA != '0);
        hiddenB  = (expB != '0);
        // Ordering uses the raw encoding, which is monotonic in magnitude
        // even across the subnormal/normal boundary; ties go to A.
        aIsLarge = {expA, fracA} >= {expB, fracB};
        equalMag = {expA, fracA} == {expB, fracB};
        effSubIn = signA ^ signB;

        nanA      = (expRawA == ExpOnes) && (fracRawA != '0);
        nanB      = (expRawB == ExpOnes) && (fracRawB != '0);
        infA      = (expRawA == ExpOnes) && (fracRawA == '0);
        infB      = (expRawB == ExpOnes) && (fracRawB == '0);
        specialIn = nanA | nanB | infA | infB;

        // Inf - Inf under effective subtraction is invalid, same as NaN in.
        if (nanA || nanB || (infA && infB && effSubIn)) begin
            specialResIn = QuietNaN;
        end else if (infA) begin
            specialResIn = {signA, ExpOnes, {FractionSize{1'b0}}};
        end else if (infB) begin
            specialResIn = {signB, ExpOnes, {FractionSize{1'b0}}};
        end else begin
            specialResIn = '0;
        end
    end

    // ------------------------------------------------------------------
    // S1 register next-state: load a new pair only on accept
    // ------------------------------------------------------------------
    logic [ExponentSize-1:0] s1ExpBase_q, s1ExpBase_d;
    logic [MantissaSize-1:0] s1MantLarge_q, s1MantLarge_d;
    logic [MantissaSize-1:0] s1MantSmall_q, s1MantSmall_d;
    logic [ExponentSize-1:0] s1Shift_q, s1Shift_d;
    logic                    s1EffSub_q, s1EffSub_d;
    logic                    s1Sign_q, s1Sign_d;
    logic                    s1Special_q, s1Special_d;
    logic [DataSize-1:0]     s1SpecialRes_q, s1SpecialRes_d;

    always_comb begin
        s1Valid_d      = s1Valid_q;
        s1ExpBase_d    = s1ExpBase_q;
        s1MantLarge_d  = s1MantLarge_q;
        s1MantSmall_d  = s1MantSmall_q;
        s1Shift_d      = s1Shift_q;
        s1EffSub_d     = s1EffSub_q;
        s1Sign_d       = s1Sign_q;
        s1Special_d    = s1Special_q;
        s1SpecialRes_d = s1SpecialRes_q;
        if (s1Advance) begin
            s1Valid_d = InValid;
            if (InValid) begin
                s1EffSub_d     = effSubIn;
                s1Special_d    = specialIn;
                s1SpecialRes_d = specialResIn;
                if (specialIn) begin
                    s1ExpBase_d   = '0;
                    s1MantLarge_d = '0;
                    s1MantSmall_d = '0;
                    s1Shift_d     = '0;
                    s1Sign_d      = specialResIn[DataSize-1];
                end else if (aIsLarge) begin
                    s1ExpBase_d   = expEffA;
                    s1MantLarge_d = {hiddenA, fracA};
                    s1MantSmall_d = {hiddenB, fracB};
                    s1Shift_d     = expEffA - expEffB;
                    // x - x rounds to +0 under round-to-nearest
                    s1Sign_d      = (effSubIn && equalMag) ? 1'b0 : signA;
                end else begin
                    s1ExpBase_d   = expEffB;
                    s1MantLarge_d = {hiddenB, fracB};
                    s1MantSmall_d = {hiddenA, fracA};
                    s1Shift_d     = expEffB - expEffA;
                    s1Sign_d      = signB;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Alignment shifter: everything shifted past bit 0 is folded into the
    // sticky bit so rounding downstream sees any lost precision.
    // ------------------------------------------------------------------
    logic [RoundingSize-1:0] mantWide, shifted, lostMask, alignedSmall;

    always_comb begin
        mantWide = {s1MantSmall_q, 3'b000};
        shifted  = mantWide >> s1Shift_q;
        lostMask = ~({RoundingSize{1'b1}} << s1Shift_q);
        if (s1Shift_q >= RoundLimit) begin
            alignedSmall = {{(RoundingSize-1){1'b0}}, |s1MantSmall_q};
        end else begin
            alignedSmall = {shifted[RoundingSize-1:1],
                            shifted[0] | (|(mantWide & lostMask))};
        end
    end

    // ------------------------------------------------------------------
    // S2 register next-state: outputs only change when the stage advances,
    // which keeps them stable under back-pressure.
    // ------------------------------------------------------------------
    logic [ExponentSize-1:0] expBase_q, expBase_d;
    logic [RoundingSize-1:0] mantLarge_q, mantLarge_d;
    logic [RoundingSize-1:0] mantSmall_q, mantSmall_d;
    logic                    effSub_q, effSub_d;
    logic                    sign_q, sign_d;
    logic                    special_q, special_d;
    logic [DataSize-1:0]     specialRes_q, specialRes_d;

    always_comb begin
        outValid_d   = outValid_q;
        expBase_d    = expBase_q;
        mantLarge_d  = mantLarge_q;
        mantSmall_d  = mantSmall_q;
        effSub_d     = effSub_q;
        sign_d       = sign_q;
        special_d    = special_q;
        specialRes_d = specialRes_q;
        if (s2Advance) begin
            outValid_d = s1Valid_q;
            if (s1Valid_q) begin
                expBase_d    = s1ExpBase_q;
                mantLarge_d  = {s1MantLarge_q, 3'b000};
                mantSmall_d  = alignedSmall;
                effSub_d     = s1EffSub_q;
                sign_d       = s1Sign_q;
                special_d    = s1Special_q;
                specialRes_d = s1SpecialRes_q;
            end
        end
    end

    // ------------------------------------------------------------------
    // State registers for both stages
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            s1Valid_q      <= 1'b0;
            s1ExpBase_q    <= '0;
            s1MantLarge_q  <= '0;
            s1MantSmall_q  <= '0;
            s1Shift_q      <= '0;
            s1EffSub_q     <= 1'b0;
            s1Sign_q       <= 1'b0;
            s1Special_q    <= 1'b0;
            s1SpecialRes_q <= '0;
            outValid_q     <= 1'b0;
            expBase_q      <= '0;
            mantLarge_q    <= '0;
            mantSmall_q    <= '0;
            effSub_q       <= 1'b0;
            sign_q         <= 1'b0;
            special_q      <= 1'b0;
            specialRes_q   <= '0;
        end else begin
            s1Valid_q      <= s1Valid_d;
            s1ExpBase_q    <= s1ExpBase_d;
            s1MantLarge_q  <= s1MantLarge_d;
            s1MantSmall_q  <= s1MantSmall_d;
            s1Shift_q      <= s1Shift_d;
            s1EffSub_q     <= s1EffSub_d;
            s1Sign_q       <= s1Sign_d;
            s1Special_q    <= s1Special_d;
            s1SpecialRes_q <= s1SpecialRes_d;
            outValid_q     <= outValid_d;
            expBase_q      <= expBase_d;
            mantLarge_q    <= mantLarge_d;
            mantSmall_q    <= mantSmall_d;
            effSub_q       <= effSub_d;
            sign_q         <= sign_d;
            special_q      <= special_d;
            specialRes_q   <= specialRes_d;
        end
    end

    assign OutValid      = outValid_q;
    assign ExponentBase  = expBase_q;
    assign MantissaLarge = mantLarge_q;
    assign MantissaSmall = mantSmall_q;
    assign EffSub        = effSub_q;
    assign ResultSign    = sign_q;
    assign SpecialCase   = special_q;
    assign SpecialResult = specialRes_q;

endmodule

// File: tb/tb_fp_align_stage.sv
// ----------------------------------------------------------------------------
// tb_fp_align_stage
//
// Directed bench for fp_align_stage. Expected bundles are hand-computed from
// the IEEE encodings of each vector. Inputs are driven on the falling edge
// and outputs sampled shortly after it, away from the active rising edge.
// ----------------------------------------------------------------------------
module tb_fp_align_stage;

    typedef struct {
        logic [7:0]  expBase;
        logic [26:0] mantL;
        logic [26:0] mantS;
        logic        effSub;
        logic        sign;
        logic        spec;
        logic [31:0] specRes;
    } bundle_t;

    logic        Clk;
    logic        Rst_n;
    logic        InValid;
    logic        InReady;
    logic [31:0] OperandA;
    logic [31:0] OperandB;
    logic        Operation;
    logic        OutValid;
    logic        OutReady;
    logic [7:0]  ExponentBase;
    logic [26:0] MantissaLarge;
    logic [26:0] MantissaSmall;
    logic        EffSub;
    logic        ResultSign;
    logic        SpecialCase;
    logic [31:0] SpecialResult;

    int checks = 0;
    int errors = 0;

    fp_align_stage dut (
        .Clk          (Clk),
        .Rst_n        (Rst_n),
        .InValid      (InValid),
        .InReady      (InReady),
        .OperandA     (OperandA),
        .OperandB     (OperandB),
        .Operation    (Operation),
        .OutValid     (OutValid),
        .OutReady     (OutReady),
        .ExponentBase (ExponentBase),
        .MantissaLarge(MantissaLarge),
        .MantissaSmall(MantissaSmall),
        .EffSub       (EffSub),
        .ResultSign   (ResultSign),
        .SpecialCase  (SpecialCase),
        .SpecialResult(SpecialResult)
    );

    // 100 MHz free-running clock
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Hard stop in case a wait is ever left unbounded
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present one pair for a single cycle into an idle pipe
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic op);
        @(negedge Clk);
        OperandA  = a;
        OperandB  = b;
        Operation = op;
        InValid   = 1'b1;
        OutReady  = 1'b1;
        #1;
        check("inReadyIdle", {31'b0, InReady}, 32'd1);
        @(posedge Clk);
        #1;
        InValid = 1'b0;
    endtask

    task automatic waitForOutput(input string tag);
        int n = 0;
        do begin
            @(negedge Clk);
            n++;
        end while (!OutValid && n < 8);
        check({tag, ".valid"}, {31'b0, OutValid}, 32'd1);
    endtask

    task automatic checkOutput(input string tag, input bundle_t e, input bit withSign);
        check({tag, ".exp"},     {24'b0, ExponentBase},  {24'b0, e.expBase});
        check({tag, ".mantL"},   {5'b0, MantissaLarge},  {5'b0, e.mantL});
        check({tag, ".mantS"},   {5'b0, MantissaSmall},  {5'b0, e.mantS});
        check({tag, ".effSub"},  {31'b0, EffSub},        {31'b0, e.effSub});
        check({tag, ".spec"},    {31'b0, SpecialCase},   {31'b0, e.spec});
        if (e.spec)
            check({tag, ".specRes"}, SpecialResult, e.specRes);
        if (withSign)
            check({tag, ".sign"}, {31'b0, ResultSign}, {31'b0, e.sign});
    endtask

    task automatic runVector(input string tag, input logic [31:0] a, input logic [31:0] b,
                             input logic op, input bundle_t e, input bit withSign);
        applyStimulus(a, b, op);
        waitForOutput(tag);
        checkOutput(tag, e, withSign);
    endtask

    initial begin
        bundle_t     e;
        bundle_t     bpExp [4];
        logic [31:0] bpA [4];
        logic [31:0] bpB [4];
        logic        bpOp [4];
        int          inIdx, outIdx, lastDrain;
        logic        sawLow, holdPrev, accept, drain, sawValid;
        logic [7:0]  prevExp;
        logic [26:0] prevMantS;

        Rst_n     = 1'b0;
        InValid   = 1'b0;
        OutReady  = 1'b0;
        OperandA  = '0;
        OperandB  = '0;
        Operation = 1'b0;

        // Reset state
        #12;
        check("rst.outValid", {31'b0, OutValid}, 32'd0);
        check("rst.inReady",  {31'b0, InReady}, 32'd1);
        check("rst.exp",      {24'b0, ExponentBase}, 32'd0);
        check("rst.mantL",    {5'b0, MantissaLarge}, 32'd0);
        @(negedge Clk);
        Rst_n = 1'b1;
        #1;
        check("postRst.inReady", {31'b0, InReady}, 32'd1);

        // 1.0 + 1.0 with explicit two-cycle latency
        applyStimulus(32'h3F800000, 32'h3F800000, 1'b0);
        @(negedge Clk);
        check("lat.cycle1", {31'b0, OutValid}, 32'd0);
        @(negedge Clk);
        check("lat.cycle2", {31'b0, OutValid}, 32'd1);
        e = '{8'h7F, 27'h4000000, 27'h4000000, 1'b0, 1'b0, 1'b0, 32'h0};
        checkOutput("add11", e, 1'b1);

        // 1.0 - 0.5
        e = '{8'h7F, 27'h4000000, 27'h2000000, 1'b1, 1'b0, 1'b0, 32'h0};
        runVector("sub1h", 32'h3F800000, 32'h3F000000, 1'b1, e, 1'b1);

        // d = 24 with sticky from the LSB of B
        e = '{8'h97, 27'h4000000, 27'h0000005, 1'b0, 1'b0, 1'b0, 32'h0};
        runVector("d24", 32'h4B800000, 32'h3F800001, 1'b0, e, 1'b1);

        // d = 31, beyond the shifter width
        e = '{8'h9E, 27'h4000000, 27'h0000001, 1'b0, 1'b0, 1'b0, 32'h0};
        runVector("d31", 32'h4F000000, 32'h3F800000, 1'b0, e, 1'b1);

        // B larger: -1.0 + 3.0 swaps operands
        e = '{8'h80, 27'h6000000, 27'h2000000, 1'b1, 1'b0, 1'b0, 32'h0};
        runVector("swap", 32'hBF800000, 32'h40400000, 1'b0, e, 1'b1);

        // (-1.0) - (-1.0): equal magnitudes under subtraction give +0
        e = '{8'h7F, 27'h4000000, 27'h4000000, 1'b1, 1'b0, 1'b0, 32'h0};
        runVector("eqSub", 32'hBF800000, 32'hBF800000, 1'b1, e, 1'b1);

        // Specials
        e = '{8'h00, 27'h0, 27'h0, 1'b0, 1'b0, 1'b1, 32'h7FC00000};
        runVector("nanA", 32'h7FC00000, 32'h3F800000, 1'b0, e, 1'b0);
        e = '{8'h00, 27'h0, 27'h0, 1'b1, 1'b0, 1'b1, 32'h7FC00000};
        runVector("infSubInf", 32'h7F800000, 32'h7F800000, 1'b1, e, 1'b0);
        e = '{8'h00, 27'h0, 27'h0, 1'b1, 1'b0, 1'b1, 32'hFF800000};
        runVector("negInf", 32'hFF800000, 32'h3F800000, 1'b0, e, 1'b0);
        e = '{8'h00, 27'h0, 27'h0, 1'b1, 1'b0, 1'b1, 32'hFF800000};
        runVector("infBsub", 32'h3F800000, 32'h7F800000, 1'b1, e, 1'b0);

        // Subnormal handling
`ifdef SUBNORMAL_EN
        e = '{8'h01, 27'h0000010, 27'h0000008, 1'b0, 1'b0, 1'b0, 32'h0};
`else
        e = '{8'h00, 27'h0, 27'h0, 1'b0, 1'b0, 1'b0, 32'h0};
`endif
        runVector("subn", 32'h00000002, 32'h00000001, 1'b0, e, 1'b1);

        // Back-pressure: 4 pairs streamed, OutReady low for cycles 3..5
        bpA[0] = 32'h3F800000; bpB[0] = 32'h3F800000; bpOp[0] = 1'b0;
        bpA[1] = 32'h3F800000; bpB[1] = 32'h3F000000; bpOp[1] = 1'b1;
        bpA[2] = 32'h40000000; bpB[2] = 32'h3F800000; bpOp[2] = 1'b0;
        bpA[3] = 32'hBF800000; bpB[3] = 32'h40400000; bpOp[3] = 1'b0;
        bpExp[0] = '{8'h7F, 27'h4000000, 27'h4000000, 1'b0, 1'b0, 1'b0, 32'h0};
        bpExp[1] = '{8'h7F, 27'h4000000, 27'h2000000, 1'b1, 1'b0, 1'b0, 32'h0};
        bpExp[2] = '{8'h80, 27'h4000000, 27'h2000000, 1'b0, 1'b0, 1'b0, 32'h0};
        bpExp[3] = '{8'h80, 27'h6000000, 27'h2000000, 1'b1, 1'b0, 1'b0, 32'h0};
        @(negedge Clk);
        inIdx     = 0;
        outIdx    = 0;
        lastDrain = -1;
        sawLow    = 1'b0;
        holdPrev  = 1'b0;
        prevExp   = '0;
        prevMantS = '0;
        for (int c = 0; c < 16; c++) begin
            @(negedge Clk);
            if (inIdx < 4) begin
                OperandA  = bpA[inIdx];
                OperandB  = bpB[inIdx];
                Operation = bpOp[inIdx];
                InValid   = 1'b1;
            end else begin
                InValid = 1'b0;
            end
            OutReady = !(c >= 3 && c <= 5);
            #1;
            if (holdPrev) begin
                check("hold.valid", {31'b0, OutValid}, 32'd1);
                check("hold.exp",   {24'b0, ExponentBase}, {24'b0, prevExp});
                check("hold.mantS", {5'b0, MantissaSmall}, {5'b0, prevMantS});
            end
            if (!InReady) sawLow = 1'b1;
            accept = InValid && InReady;
            drain  = OutValid && OutReady;
            if (drain && outIdx < 4)
                checkOutput($sformatf("bp%0d", outIdx), bpExp[outIdx], 1'b1);
            holdPrev  = OutValid && !OutReady;
            prevExp   = ExponentBase;
            prevMantS = MantissaSmall;
            @(posedge Clk);
            if (accept) inIdx++;
            if (drain) begin
                outIdx++;
                lastDrain = c;
            end
        end
        InValid = 1'b0;
        check("bp.accepted",  inIdx, 32'd4);
        check("bp.drained",   outIdx, 32'd4);
        check("bp.lastDrain", lastDrain, 32'd8);
        check("bp.inReadyLow", {31'b0, sawLow}, 32'd1);

        // Reset with two pairs in flight
        @(negedge Clk);
        OperandA  = 32'h3F800000;
        OperandB  = 32'h3F000000;
        Operation = 1'b0;
        InValid   = 1'b1;
        OutReady  = 1'b0;
        @(negedge Clk);
        OperandA  = 32'h40000000;
        @(negedge Clk);
        InValid = 1'b0;
        #1;
        check("preRst.valid", {31'b0, OutValid}, 32'd1);
        #2;
        Rst_n = 1'b0;
        #1;
        check("midRst.valid", {31'b0, OutValid}, 32'd0);
        check("midRst.exp",   {24'b0, ExponentBase}, 32'd0);
        check("midRst.mantL", {5'b0, MantissaLarge}, 32'd0);
        check("midRst.mantS", {5'b0, MantissaSmall}, 32'd0);
        check("midRst.inReady", {31'b0, InReady}, 32'd1);
        @(negedge Clk);
        Rst_n    = 1'b1;
        OutReady = 1'b1;
        sawValid = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge Clk);
            if (OutValid) sawValid = 1'b1;
        end
        check("postRst.noEmit", {31'b0, sawValid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
